serial_add_ctrl: RTL

- Sequencer that performs a WIDTH-bit addition bit-serially through one shared 1-bit full-adder cell, built from two half-adder cells and an OR gate.
- It captures the operands, steps the adder once per clock from LSB to MSB, and collects the sum bits and carry.
- It presents the result through a start/busy/done handshake.
- It sits between a requesting datapath and the team's half-adder primitives. It trades area for latency.

---
 rtl/serial_add_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial WIDTH-bit adder sequencer: one shared full-adder cell (two half-adder
// cells plus an OR) stepped LSB to MSB, with a start/busy/done handshake.
//
// state | meaning
// IDLE  | waiting for start; last result held on sum/cout/ovf
// RUN   | one operand bit added per clock, cnt counts bits done
// DONE  | one-cycle result pulse; start here re-enters RUN with no bubble
module serial_add_ctrl #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic [1:0]       ha0;
    logic [1:0]       ha1;
    logic             carry_next;
    logic [WIDTH-1:0] res_next;
    logic             last_bit;

    // Half-adder cell, returns {carry, sum}
    function automatic logic [1:0] half_add(input logic x, input logic y);
        return {x & y, x ^ y};
    endfunction

    always_comb begin
        ha0        = half_add(a_sh[0], b_sh[0]);
        ha1        = half_add(ha0[0], carry);
        carry_next = ha0[1] | ha1[1];
        res_next   = {ha1[0], res_sh[WIDTH-1:1]};
        last_bit   = (cnt == CNT_W'(WIDTH - 1));
    end

    assign ready = (state == IDLE) || (state == DONE);
    assign busy  = (state == RUN);
    assign done  = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sh   <= '0;
            b_sh   <= '0;
            res_sh <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        a_sh  <= a;
                        b_sh  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                    end else begin
                        a_sh   <= a_sh >> 1;
                        b_sh   <= b_sh >> 1;
                        res_sh <= res_next;
                        carry  <= carry_next;
                        cnt    <= cnt + CNT_W'(1);
                        if (last_bit) begin
                            sum   <= res_next;
                            cout  <= carry_next;
                            // carry here is the carry into the MSB
                            ovf   <= carry ^ carry_next;
                            state <= DONE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
